// File: rtl/vga_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fetch_ctrl
// Description : Pixel fetch scheduler between frame memory and the VGA
//               timing/colour stage. It reads 32-bit words, each holding two
//               12-bit pixels, over a req/gnt/rvalid port that allows one
//               outstanding read. Words go into a two-word ping-pong buffer.
//               One pixel is served for each data_req_i cycle.
//               frame_start_i flushes the buffer and restarts at the frame
//               base address. A pop of an empty buffer sets a sticky
//               underflow flag.
// Option      : `define VGA_FETCH_UFLOW_CNT_EN adds a saturating 16-bit
//               underflow event counter. Without it, uflow_cnt_o is 0 and
//               the counter has no flops.
// Ports       : clk, resetn (async, active-low)
//               enable_i       - allow new memory requests
//               base_addr_i    - frame base byte address (sampled on start)
//               frame_words_i  - words per frame (sampled on start)
//               frame_start_i  - flush buffer, restart at base
//               data_req_i     - pixel consumed this cycle
//               data_o         - current pixel, 0 when buffer empty
//               mem_req_o/mem_addr_o/mem_gnt_i/mem_rvalid_i/mem_rdata_i
//                              - single-outstanding read port
//               underflow_o    - sticky pop-on-empty flag
//               busy_o         - request or response in flight
//               uflow_cnt_o    - underflow event count (optional)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fetch_ctrl #(
    parameter int AW   = 32,
    parameter int FW_W = 20
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable_i,
    input  logic [AW-1:0]   base_addr_i,
    input  logic [FW_W-1:0] frame_words_i,
    input  logic            frame_start_i,
    input  logic            data_req_i,
    output logic [11:0]     data_o,
    output logic            mem_req_o,
    output logic [AW-1:0]   mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            underflow_o,
    output logic            busy_o,
    output logic [15:0]     uflow_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    // Each bank keeps only the two pixel fields: {pixel1, pixel0}.
    logic [1:0][23:0]  bank_q, bank_d;
    logic [1:0]        valid_q, valid_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic              pix_sel_q, pix_sel_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [FW_W-1:0]   words_left_q, words_left_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              underflow_q, underflow_d;
    logic              next_ok;

    // The nibbles between the pixel fields carry no pixel information.
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^{mem_rdata_i[31:28], mem_rdata_i[15:12]};

    assign data_o = !valid_q[rd_bank_q] ? 12'h000 :
                    (pix_sel_q ? bank_q[rd_bank_q][23:12] : bank_q[rd_bank_q][11:0]);

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = addr_q;
    assign busy_o      = busy_q;
    assign underflow_o = underflow_q;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        valid_d      = valid_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        pix_sel_d    = pix_sel_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        underflow_d  = underflow_q;

        if (frame_start_i) begin
            valid_d      = 2'b00;
            rd_bank_d    = 1'b0;
            wr_bank_d    = 1'b0;
            pix_sel_d    = 1'b0;
            underflow_d  = 1'b0;
            addr_d       = base_addr_i;
            words_left_d = frame_words_i;
        end else begin
            // The consumer pops from rd_bank and the fill writes wr_bank.
            // Both can happen in the same cycle: a fill only lands on an
            // invalid bank and a pop only drains a valid one.
            if (data_req_i) begin
                if (valid_q[rd_bank_q]) begin
                    pix_sel_d = ~pix_sel_q;
                    if (pix_sel_q) begin
                        valid_d[rd_bank_q] = 1'b0;
                        rd_bank_d          = ~rd_bank_q;
                    end
                end else begin
                    underflow_d = 1'b1;
                end
            end
            if (state_q == S_WAIT && mem_rvalid_i) begin
                bank_d[wr_bank_q]  = {mem_rdata_i[27:16], mem_rdata_i[11:0]};
                valid_d[wr_bank_q] = 1'b1;
                wr_bank_d          = ~wr_bank_q;
            end
            if (state_q == S_REQ && mem_gnt_i) begin
                addr_d = addr_q + AW'(4);
                if (words_left_q != '0) begin
                    words_left_d = words_left_q - FW_W'(1);
                end
            end
        end

        // A new request may follow a fill directly. The check uses the
        // buffer state after this cycle's fill and pop.
        next_ok = enable_i && !valid_d[wr_bank_d] && (words_left_q != '0);

        case (state_q)
            S_IDLE:  if (enable_i && !valid_q[wr_bank_q] && words_left_q != '0) state_d = S_REQ;
            S_REQ:   if (mem_gnt_i) state_d = S_WAIT;
            S_WAIT:  if (mem_rvalid_i) begin
                         if (words_left_q == '0) state_d = S_DONE;
                         else                    state_d = next_ok ? S_REQ : S_IDLE;
                     end
            S_DRAIN: if (mem_rvalid_i) state_d = S_IDLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // A restart must still absorb a response that has already been
        // granted. That response is discarded in DRAIN. A response arriving
        // in the restart cycle itself is dropped along with the flush.
        if (frame_start_i) begin
            case (state_q)
                S_REQ:   state_d = mem_gnt_i ? S_DRAIN : S_IDLE;
                S_WAIT:  state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                S_DRAIN: state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end

        mem_req_d = (state_d == S_REQ);
        busy_d    = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            bank_q       <= '0;
            valid_q      <= 2'b00;
            rd_bank_q    <= 1'b0;
            wr_bank_q    <= 1'b0;
            pix_sel_q    <= 1'b0;
            addr_q       <= '0;
            words_left_q <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            valid_q      <= valid_d;
            rd_bank_q    <= rd_bank_d;
            wr_bank_q    <= wr_bank_d;
            pix_sel_q    <= pix_sel_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            mem_req_q    <= mem_req_d;
            busy_q       <= busy_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef VGA_FETCH_UFLOW_CNT_EN
    logic [15:0] uflow_cnt_q, uflow_cnt_d;

    always_comb begin
        uflow_cnt_d = uflow_cnt_q;
        // A restart outranks an underflow in the same cycle.
        if (data_req_i && !valid_q[rd_bank_q] && !frame_start_i && uflow_cnt_q != 16'hFFFF) begin
            uflow_cnt_d = uflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) uflow_cnt_q <= 16'h0000;
        else         uflow_cnt_q <= uflow_cnt_d;
    end

    assign uflow_cnt_o = uflow_cnt_q;
`else
    assign uflow_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fetch_ctrl
// Description : Bench for vga_fetch_ctrl. A memory responder returns random
//               words with configurable grant and response latency. The
//               reference model works at the frame level. The frame is a
//               sequence of word addresses starting at base. Each returned
//               word yields two pixels in a FIFO. A response is lost if a
//               restart or reset happens between its grant and its delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable_i;
    logic [31:0] base_addr_i;
    logic [19:0] frame_words_i;
    logic        frame_start_i;
    logic        data_req_i;
    logic [11:0] data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        underflow_o;
    logic        busy_o;
    logic [15:0] uflow_cnt_o;

    vga_fetch_ctrl #(.AW(32), .FW_W(20)) dut (
        .clk(clk), .resetn(resetn), .enable_i(enable_i),
        .base_addr_i(base_addr_i), .frame_words_i(frame_words_i),
        .frame_start_i(frame_start_i), .data_req_i(data_req_i), .data_o(data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .underflow_o(underflow_o), .busy_o(busy_o), .uflow_cnt_o(uflow_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [11:0] pixq[$];          // pixels expected on data_o, in order
    logic [31:0] m_addr;           // next word address of the frame
    int          m_left;           // words of the frame not yet granted
    bit          m_inflight;       // granted response not yet delivered
    bit          m_discard;        // that response belongs to a dead frame
    bit          m_uflow;
    int          m_cnt;
    int          grants;
    bit          p_hold;           // request pending without grant last cycle
    logic [31:0] p_addr;

    always @(negedge clk) begin
        if (!resetn) begin
            pixq.delete();
            m_addr = 0; m_left = 0; m_inflight = 0; m_discard = 0;
            m_uflow = 0; m_cnt = 0; p_hold = 0;
        end else begin
            chk("data_o", {20'h0, data_o}, (pixq.size() != 0) ? {20'h0, pixq[0]} : 32'h0);
            chk("underflow_o", underflow_o, m_uflow);
            chk("busy_o", busy_o, mem_req_o | m_inflight);
            chk("uflow_cnt_o", uflow_cnt_o, m_cnt);
            if (p_hold) begin
                chk("req_held", mem_req_o, 1);
                chk("addr_held", mem_addr_o, p_addr);
            end
            p_hold = mem_req_o & !mem_gnt_i & !frame_start_i;
            p_addr = mem_addr_o;

            // Consumer side, against the buffer contents before this cycle's fill.
            if (!frame_start_i && data_req_i) begin
                if (pixq.size() != 0) void'(pixq.pop_front());
                else begin
                    m_uflow = 1;
`ifdef VGA_FETCH_UFLOW_CNT_EN
                    if (m_cnt < 16'hFFFF) m_cnt++;
`endif
                end
            end

            if (mem_req_o && mem_gnt_i) begin
                chk("req_addr", mem_addr_o, m_addr);
                chk("req_within_frame", (m_left > 0), 1);
                grants++;
                m_addr = m_addr + 32'd4;
                if (m_left > 0) m_left--;
                m_inflight = 1;
                m_discard  = frame_start_i;
            end else if (mem_rvalid_i && m_inflight) begin
                if (!m_discard && !frame_start_i) begin
                    pixq.push_back(mem_rdata_i[11:0]);
                    pixq.push_back(mem_rdata_i[27:16]);
                end
                m_inflight = 0;
            end else if (m_inflight && frame_start_i) begin
                m_discard = 1;
            end

            if (frame_start_i) begin
                pixq.delete();
                m_uflow = 0;
                m_addr  = base_addr_i;
                m_left  = int'(frame_words_i);
            end
        end
    end

    // ---------------- memory responder ----------------
    int gmin = 0, gmax = 0, rmin = 1, rmax = 1;
    int gcnt = 0, rcnt = 0;
    bit outstanding = 0;

    initial begin
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        forever begin
            @(posedge clk); #1;
            mem_gnt_i = 0; mem_rvalid_i = 0;
            if (!mem_req_o) gcnt = $urandom_range(gmax, gmin);
            if (outstanding) begin
                if (rcnt == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i  = $urandom;
                    outstanding  = 0;
                end else rcnt--;
            end else if (mem_req_o) begin
                if (gcnt == 0) begin
                    mem_gnt_i   = 1;
                    outstanding = 1;
                    rcnt = $urandom_range(rmax, rmin) - 1;
                    gcnt = $urandom_range(gmax, gmin);
                end else gcnt--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input logic [31:0] b, input int w);
        base_addr_i   = b;
        frame_words_i = w[19:0];
        frame_start_i = 1;
        tick();
        frame_start_i = 0;
    endtask

    int g0, c, cut;
    bit found, done, intr;
    logic [31:0] rb;
    int rw;

    initial begin
        resetn = 0; enable_i = 0; base_addr_i = 0; frame_words_i = 0;
        frame_start_i = 0; data_req_i = 0; grants = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        tick();

        // Two words fill the buffer and fetching stalls.
        enable_i = 1; gmin = 0; gmax = 0; rmin = 1; rmax = 1;
        g0 = grants;
        start_frame(32'h1000, 4);
        repeat (20) tick();
        chk("c1_grants", grants - g0, 2);
        chk("c1_busy", busy_o, 0);
        chk("c1_req", mem_req_o, 0);

        // The consumer drains the frame and then underflows.
        data_req_i = 1;
        repeat (30) tick();
        data_req_i = 0;
        chk("c2_grants", grants - g0, 4);
        chk("c2_underflow", underflow_o, 1);
        chk("c2_data", data_o, 0);
        chk("c2_busy", busy_o, 0);

        // The grant is delayed by 5 cycles.
        gmin = 5; gmax = 5;
        g0 = grants;
        start_frame(32'h2000, 1);
        repeat (20) tick();
        chk("c3_grants", grants - g0, 1);
        data_req_i = 1; repeat (3) tick(); data_req_i = 0;

        // A restart while waiting on read data.
        gmin = 0; gmax = 0; rmin = 4; rmax = 4;
        start_frame(32'h3000, 4);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (busy_o && !mem_req_o) found = 1; else tick();
        end
        chk("c4_reach_wait", found, 1);
        start_frame(32'h4000, 2);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_req_o) found = 1; else tick();
        end
        chk("c4_new_req", found, 1);
        chk("c4_new_addr", mem_addr_o, 32'h4000);
        repeat (20) tick();

        // Asynchronous reset in the middle of a wait.
        rmin = 6; rmax = 6;
        start_frame(32'h5000, 3);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (busy_o && !mem_req_o) found = 1; else tick();
        end
        chk("c6_reach_wait", found, 1);
        #2 resetn = 0;
        #1;
        chk("c6_req", mem_req_o, 0);
        chk("c6_addr", mem_addr_o, 0);
        chk("c6_busy", busy_o, 0);
        chk("c6_underflow", underflow_o, 0);
        chk("c6_cnt", uflow_cnt_o, 0);
        chk("c6_data", data_o, 0);
        tick();
        resetn = 1;
        repeat (12) tick();
        chk("c6_no_fill", data_o, 0);

        // A zero-word frame only underflows.
        g0 = grants;
        start_frame(32'h6000, 0);
        data_req_i = 1; repeat (3) tick(); data_req_i = 0;
        repeat (5) tick();
        chk("c5_grants", grants - g0, 0);
        chk("c5_underflow", underflow_o, 1);
`ifdef VGA_FETCH_UFLOW_CNT_EN
        chk("c5_cnt", uflow_cnt_o, 3);
`else
        chk("c5_cnt", uflow_cnt_o, 0);
`endif

        // Random frames, some of them interrupted by a restart.
        for (int f = 0; f < 30; f++) begin
            rb = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            rw = $urandom_range(10, 1);
            gmin = 0; gmax = $urandom_range(3, 0);
            rmin = 1; rmax = $urandom_range(3, 1);
            enable_i = 1;
            start_frame(rb, rw);
            intr = ($urandom_range(3, 0) == 0);
            cut  = $urandom_range(15, 1);
            done = 0;
            for (c = 0; c < 400 && !done; c++) begin
                enable_i   = ($urandom_range(7, 0) != 0);
                data_req_i = $urandom_range(1, 0);
                tick();
                if (intr && c == cut) done = 1;
                else if (m_left == 0 && !m_inflight && pixq.size() == 0 && !mem_req_o) done = 1;
            end
            data_req_i = 0; enable_i = 1;
            if (!intr) chk("frame_complete", done, 1);
        end
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", fails);
        $fatal(1);
    end

endmodule
`default_nettype wire
